// File: rtl/regfile16_flags_if.sv
// Operand/write-back/flag bundle between the datapath control and the register file.
// The master drives requests; the slave (register file) returns operands and flags.
interface regfile16_flags_if #(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_REGS   = 8
);
    localparam int ADDR_W = $clog2(NUM_REGS);

    logic                  read_enable;
    logic [ADDR_W-1:0]     read_addr1;
    logic [ADDR_W-1:0]     read_addr2;
    logic [DATA_WIDTH-1:0] read_data1;
    logic [DATA_WIDTH-1:0] read_data2;
    logic                  read_valid;

    logic                  write_enable;
    logic [ADDR_W-1:0]     write_addr;
    logic [DATA_WIDTH-1:0] write_data;

    logic                  flag_write;
    logic                  zero_in;
    logic                  overflow_in;
    logic                  carry_in;
    logic                  zero_flag;
    logic                  overflow_flag;
    logic                  carry_flag;

    modport master (
        output read_enable, read_addr1, read_addr2,
        output write_enable, write_addr, write_data,
        output flag_write, zero_in, overflow_in, carry_in,
        input  read_data1, read_data2, read_valid,
        input  zero_flag, overflow_flag, carry_flag
    );

    modport slave (
        input  read_enable, read_addr1, read_addr2,
        input  write_enable, write_addr, write_data,
        input  flag_write, zero_in, overflow_in, carry_in,
        output read_data1, read_data2, read_valid,
        output zero_flag, overflow_flag, carry_flag
    );
endinterface

// File: rtl/regfile16_flags.sv
// Eight-entry register file (r0 hardwired to zero) with two registered read ports,
// write-first bypass, and a 3-bit ALU status-flag register.
module regfile16_flags #(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_REGS   = 8
) (
    input  logic                clk,
    input  logic                rst,
    regfile16_flags_if.slave    rf_bus
);
    localparam int ADDR_W = $clog2(NUM_REGS);

    // view[a] is the value a read of address a returns this cycle, bypass included.
    logic [DATA_WIDTH-1:0] view [0:NUM_REGS-1];

    assign view[0] = '0;

    generate
        for (genvar gi = 1; gi < NUM_REGS; gi++) begin : g_reg
            logic                  wr_hit;
            logic [DATA_WIDTH-1:0] data_q;
            logic [DATA_WIDTH-1:0] data_d;

            assign wr_hit = rf_bus.write_enable && (rf_bus.write_addr == ADDR_W'(gi));
            assign data_d = wr_hit ? rf_bus.write_data : data_q;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    data_q <= '0;
                end else begin
                    data_q <= data_d;
                end
            end

            assign view[gi] = data_d;
        end
    endgenerate

    logic [DATA_WIDTH-1:0] read_data1_q, read_data1_d;
    logic [DATA_WIDTH-1:0] read_data2_q, read_data2_d;
    logic                  read_valid_q, read_valid_d;
    logic [2:0]            flags_q, flags_d;

    always_comb begin
        read_data1_d = read_data1_q;
        read_data2_d = read_data2_q;
        read_valid_d = rf_bus.read_enable;
        if (rf_bus.read_enable) begin
            read_data1_d = view[rf_bus.read_addr1];
            read_data2_d = view[rf_bus.read_addr2];
        end
    end

    always_comb begin
        flags_d = flags_q;
        if (rf_bus.flag_write) begin
            flags_d = {rf_bus.zero_in, rf_bus.overflow_in, rf_bus.carry_in};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            read_data1_q <= '0;
            read_data2_q <= '0;
            read_valid_q <= 1'b0;
            flags_q      <= 3'b000;
        end else begin
            read_data1_q <= read_data1_d;
            read_data2_q <= read_data2_d;
            read_valid_q <= read_valid_d;
            flags_q      <= flags_d;
        end
    end

    assign rf_bus.read_data1    = read_data1_q;
    assign rf_bus.read_data2    = read_data2_q;
    assign rf_bus.read_valid    = read_valid_q;
    assign rf_bus.zero_flag     = flags_q[2];
    assign rf_bus.overflow_flag = flags_q[1];
    assign rf_bus.carry_flag    = flags_q[0];
endmodule
